// File: rtl/clk_period_meter.sv
// Measures high/low run lengths of a slow input in system-clock cycles and
// publishes one result per full period, with saturation and stall reporting.
module clk_period_meter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_sig,
  input  logic        i_en,
  input  logic [15:0] i_timeout,
  output logic        o_valid,
  output logic [15:0] o_high,
  output logic [15:0] o_low,
  output logic [16:0] o_period,
  output logic        o_sym,
  output logic        o_sat,
  output logic        o_stall
);

  typedef enum logic [1:0] {IDLE, SEEK, MEAS} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_s1, r_s2, r_sd;
  logic        w_rise, w_fall;
  logic [15:0] r_hi_cnt, r_lo_cnt, r_hi_lat;
  logic        r_have_hi, r_sat_f;
  logic [15:0] w_act_cnt, w_inc_cnt;
  logic        w_act_max, w_stall_hit;

  assign w_rise    = r_s2 & ~r_sd;
  assign w_fall    = ~r_s2 & r_sd;
  assign w_act_cnt = r_s2 ? r_hi_cnt : r_lo_cnt;
  assign w_act_max = &w_act_cnt;
  assign w_inc_cnt = w_act_max ? w_act_cnt : w_act_cnt + 16'd1;
  // Stall is judged on the post-increment count; edge cycles never stall.
  assign w_stall_hit = (r_state == MEAS) & i_en & ~w_rise & ~w_fall &
                       (i_timeout != '0) & (w_inc_cnt >= i_timeout);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_sd <= 1'b0;
    end else begin
      r_s1 <= i_sig;
      r_s2 <= r_s1;
      r_sd <= r_s2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = SEEK;
        SEEK:    if (w_rise) w_state_nxt = MEAS;
        MEAS:    if (w_stall_hit) w_state_nxt = SEEK;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hi_cnt  <= '0;
      r_lo_cnt  <= '0;
      r_hi_lat  <= '0;
      r_have_hi <= 1'b0;
      r_sat_f   <= 1'b0;
      o_valid   <= 1'b0;
      o_high    <= '0;
      o_low     <= '0;
      o_period  <= '0;
      o_sym     <= 1'b0;
      o_sat     <= 1'b0;
      o_stall   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!i_en || r_state == IDLE) begin
        r_hi_cnt  <= '0;
        r_lo_cnt  <= '0;
        r_hi_lat  <= '0;
        r_have_hi <= 1'b0;
        r_sat_f   <= 1'b0;
        if (!i_en) o_stall <= 1'b0;
      end else if (r_state == SEEK) begin
        if (w_rise) begin
          r_hi_cnt  <= 16'd1;
          r_have_hi <= 1'b0;
          r_sat_f   <= 1'b0;
        end
      end else if (r_state == MEAS) begin
        if (w_rise) begin
          if (r_have_hi) begin
            o_high   <= r_hi_lat;
            o_low    <= r_lo_cnt;
            o_period <= {1'b0, r_hi_lat} + {1'b0, r_lo_cnt};
            o_sym    <= (r_hi_lat == r_lo_cnt);
            o_sat    <= r_sat_f;
            o_valid  <= 1'b1;
            o_stall  <= 1'b0;
          end
          r_hi_cnt  <= 16'd1;
          r_sat_f   <= 1'b0;
          r_have_hi <= 1'b0;
        end else if (w_fall) begin
          r_hi_lat  <= r_hi_cnt;
          r_lo_cnt  <= 16'd1;
          r_have_hi <= 1'b1;
        end else begin
          if (r_s2) r_hi_cnt <= w_inc_cnt;
          else      r_lo_cnt <= w_inc_cnt;
          if (w_act_max) r_sat_f <= 1'b1;
          if (w_stall_hit) begin
            o_stall   <= 1'b1;
            r_have_hi <= 1'b0;
          end
        end
      end
    end
  end

endmodule
